bcd_sevenseg_scan: RTL and testbench

Display-side consumer for the team's BCD digit counters. It takes NUM_DIGITS packed 4-bit BCD digits and decodes them to seven-segment patterns. It time-multiplexes the common anodes of a multi-digit display, with frame-synchronous input capture, leading-zero blanking and a one-cycle anti-ghosting dead time. It sits between the counter datapath and the board display pins.

---
 rtl/bcd_sevenseg_scan.sv | 126 ++++++++++++
 tb/tb_bcd_sevenseg_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed seven-segment driver for NUM_DIGITS packed BCD digits.
// It captures a snapshot of the inputs once per frame, blanks leading zeros and inserts one dead cycle per slot.
module bcd_sevenseg_scan #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0]         SLOT_MAX  = SW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF    = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]           presc_reg;
    logic [SW-1:0]           slot_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic                    frame_start_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   anode_reg;

    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    logic                    tick;
    logic                    frame_end;
    logic [3:0]              digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blanked;

    assign tick      = (presc_reg == PRESC_MAX);
    assign frame_end = tick && (slot_reg == SLOT_MAX);

    // Digit gi is a leading zero when it and every more significant digit are zero;
    // codes 10-15 are nonzero, so an invalid code stops the blanking run.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = shadow_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blanked[gi] = 1'b0;
            end else begin : g_upper
                assign blanked[gi] = BLANK_LEADING && (shadow_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // The tick cycle is forced dark so the old and new anodes never overlap.
    always_comb begin
        seg_next   = SEG_OFF;
        dp_next    = DP_OFF;
        anode_next = ANODE_OFF;
        if (!(tick || blank)) begin
            anode_next = (NUM_DIGITS'(1) << slot_reg) ^ ANODE_OFF;
            dp_next    = shadow_dp_reg[slot_reg] ^ ACTIVE_LOW;
            if (!blanked[slot_reg]) begin
                seg_next = decode(digit_arr[slot_reg]) ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg       <= '0;
            slot_reg        <= '0;
            shadow_reg      <= '0;
            shadow_dp_reg   <= '0;
            frame_start_reg <= 1'b0;
            seg_reg         <= SEG_OFF;
            dp_reg          <= DP_OFF;
            anode_reg       <= ANODE_OFF;
        end else begin
            if (tick) begin
                presc_reg <= '0;
                slot_reg  <= (slot_reg == SLOT_MAX) ? '0 : slot_reg + SW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
            if (frame_end) begin
                shadow_reg    <= digits_in;
                shadow_dp_reg <= dp_in;
            end
            frame_start_reg <= frame_end;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            anode_reg       <= anode_next;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign anode       = anode_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench: a cycle-indexed display model queues the expected outputs, and a monitor pops and compares them.
// Two instances differ only in leading-zero blanking.
module tb_bcd_sevenseg_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank = 1'b0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  anode_a, anode_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    bcd_sevenseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
        .seg(seg_a), .dp(dp_a), .anode(anode_a), .frame_start(fs_a)
    );

    bcd_sevenseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
        .seg(seg_b), .dp(dp_b), .anode(anode_b), .frame_start(fs_b)
    );

    typedef struct {
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        logic       dp;
        logic [3:0] anode;
        logic       fs;
        int         cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp = '0;
    logic [6:0]  lit_tab [16];

    initial begin
        lit_tab[0] = 7'h3F; lit_tab[1] = 7'h06; lit_tab[2] = 7'h5B; lit_tab[3] = 7'h4F;
        lit_tab[4] = 7'h66; lit_tab[5] = 7'h6D; lit_tab[6] = 7'h7D; lit_tab[7] = 7'h07;
        lit_tab[8] = 7'h7F; lit_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) lit_tab[i] = 7'h40;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv, input int at);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, at, act, expv);
        end
    endtask

    // Reference: cycle c after reset sits in slot (c/RD)%ND, and its last clock is dark.
    // The shown digits are whatever the inputs held on the final cycle of the previous frame.
    task automatic model_step();
        exp_t       e;
        int         presc;
        int         slot;
        bit         dead;
        bit         lead;
        logic [3:0] d;
        presc = cyc % RD;
        slot  = (cyc / RD) % ND;
        dead  = (presc == RD - 1) || blank;
        d     = m_dig[slot*4 +: 4];
        lead  = (slot > 0) && ((m_dig >> (4*slot)) == 16'h0);
        e.fs  = ((cyc + 1) % FRAME == 0);
        e.cyc = cyc;
        if (dead) begin
            e.anode = 4'hF;
            e.seg_a = 7'h7F;
            e.seg_b = 7'h7F;
            e.dp    = 1'b1;
        end else begin
            e.anode = ~(4'b0001 << slot);
            e.seg_b = ~lit_tab[d];
            e.seg_a = lead ? 7'h7F : e.seg_b;
            e.dp    = ~m_dp[slot];
        end
        exp_q.push_back(e);
        if (cyc % FRAME == FRAME - 1) begin
            m_dig = digits_in;
            m_dp  = dp_in;
        end
        cyc++;
    endtask

    // Called at a falling edge; the inputs apply to the next rising edge.
    task automatic drive_cycle(input logic [15:0] d, input logic [3:0] p, input logic b);
        digits_in = d;
        dp_in     = p;
        blank     = b;
        model_step();
        @(negedge clk);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_seg_a"}, seg_a, 7'h7F, -1);
        check({tag, "_anode_a"}, anode_a, 4'hF, -1);
        check({tag, "_dp_a"}, dp_a, 1'b1, -1);
        check({tag, "_fs_a"}, fs_a, 1'b0, -1);
        check({tag, "_seg_b"}, seg_b, 7'h7F, -1);
        check({tag, "_anode_b"}, anode_b, 4'hF, -1);
    endtask

    // Entered at a falling edge; reset is raised between edges and must act without a clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_off("rst_async");
        @(negedge clk);
        check_off("rst_held");
        @(negedge clk);
        rst   = 1'b0;
        cyc   = 0;
        m_dig = '0;
        m_dp  = '0;
        exp_q.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_a", seg_a, e.seg_a, e.cyc);
                check("seg_b", seg_b, e.seg_b, e.cyc);
                check("anode_a", anode_a, e.anode, e.cyc);
                check("anode_b", anode_b, e.anode, e.cyc);
                check("dp_a", dp_a, e.dp, e.cyc);
                check("dp_b", dp_b, e.dp, e.cyc);
                check("frame_start_a", fs_a, e.fs, e.cyc);
                check("frame_start_b", fs_b, e.fs, e.cyc);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r;
        logic [15:0] d;
        int          keep;
        @(negedge clk);
        do_reset();
        repeat (40) drive_cycle(16'h1234, 4'h0, 1'b0);
        repeat (32) drive_cycle(16'h0070, 4'b0100, 1'b0);
        repeat (32) drive_cycle(16'h000C, 4'h0, 1'b0);
        repeat (22) drive_cycle(16'h1111, 4'h0, 1'b0);
        repeat (26) drive_cycle(16'h9999, 4'h0, 1'b0);
        for (int i = 0; i < 40; i++) drive_cycle(16'h5678, 4'b1010, (i >= 13 && i < 23));
        repeat (7) drive_cycle(16'h4321, 4'h1, 1'b0);
        do_reset();
        for (int i = 0; i < 320; i++) begin
            r    = $urandom;
            keep = $urandom_range(0, 4);
            d    = r[15:0] & 16'(((32'h1 << (4*keep)) - 1));
            drive_cycle(d, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
